// File: rtl/uart_hex_pkg.sv
// Shared constants, state encodings and the ASCII-to-nibble decoder for the UART hex receiver.
// HEX_RX_PREFIX_EN (optional) enables the "0x" prefix in the parser.
package uart_hex_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_UA   = 8'h41;
  localparam logic [7:0] ASCII_UF   = 8'h46;
  localparam logic [7:0] ASCII_LA   = 8'h61;
  localparam logic [7:0] ASCII_LF_F = 8'h66;
  localparam logic [7:0] ASCII_LX   = 8'h78;
  localparam logic [7:0] ASCII_UX   = 8'h58;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [1:0] P_EMPTY   = 2'd0;
  localparam logic [1:0] P_ACCUM   = 2'd1;
  localparam logic [1:0] P_DISCARD = 2'd2;

  // Returns {is_digit, nibble}; nibble is 0 for non-digits.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= ASCII_ZERO && c <= ASCII_NINE)
      r = {1'b1, 4'(c - ASCII_ZERO)};
    else if (c >= ASCII_UA && c <= ASCII_UF)
      r = {1'b1, 4'(c - ASCII_UA + 8'd10)};
    else if (c >= ASCII_LA && c <= ASCII_LF_F)
      r = {1'b1, 4'(c - ASCII_LA + 8'd10)};
    return r;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_hex_cmd_rx_rx.sv
// 8N1 byte receiver: rx_pin synchroniser, start-bit validation and mid-bit sampling.
// byte_valid and frame_err are single-cycle pulses at the centre of the stop bit.
module uart_rx_8n1
  import uart_hex_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        rx_pin,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_prev;
  logic [1:0]             state;
  logic [15:0]            div;
  logic [15:0]            cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;

  assign rx_s = sync[SYNC_STAGES-1];

  // Synchroniser and edge-detect flops reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], rx_pin};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= R_IDLE;
      div        <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        R_IDLE: begin
          if (rx_prev && !rx_s) begin
            div   <= baud_div;
            cnt   <= baud_div >> 1;
            state <= R_START;
          end
        end
        R_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else if (!rx_s) begin
            cnt     <= div - 16'd1;
            bit_idx <= '0;
            state   <= R_DATA;
          end else begin
            state <= R_IDLE;
          end
        end
        R_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= div - 16'd1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= R_STOP;
          end
        end
        R_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= R_IDLE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_cmd_rx.sv
// UART hex line receiver: turns CR/LF-terminated ASCII hex lines into a 4*DIGITS-bit value.
// Optional macro HEX_RX_PREFIX_EN accepts a leading "0x"/"0X" on each line.
module uart_hex_cmd_rx
  import uart_hex_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           baud_div,
  input  logic                  rx_pin,
  output logic [4*DIGITS-1:0]   hex_val,
  output logic                  hex_valid,
  output logic                  parse_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [4:0]    dec;
  logic          term;
  logic [1:0]    pstate;
  logic [VW-1:0] acc;
  logic [CW-1:0] cnt;

  uart_rx_8n1 #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .rx_pin     (rx_pin),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign dec  = ascii_to_nibble(byte_data);
  assign term = is_term(byte_data);

  // Line parser; outputs are registered, so hex_valid/parse_err follow the terminator byte by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate    <= P_EMPTY;
      acc       <= '0;
      cnt       <= '0;
      hex_val   <= '0;
      hex_valid <= 1'b0;
      parse_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      hex_valid <= 1'b0;
      parse_err <= 1'b0;
      if (byte_valid) begin
        case (pstate)
          P_EMPTY: begin
            if (dec[4]) begin
              acc    <= VW'(dec[3:0]);
              cnt    <= CW'(1);
              pstate <= P_ACCUM;
              busy   <= 1'b1;
            end else if (!term) begin
              pstate <= P_DISCARD;
              busy   <= 1'b1;
            end
          end
          P_ACCUM: begin
            if (term) begin
`ifdef HEX_RX_PREFIX_EN
              // A bare "0x" leaves no digits behind the prefix and is rejected.
              if (cnt == '0)
                parse_err <= 1'b1;
              else
`endif
              begin
                hex_val   <= acc;
                hex_valid <= 1'b1;
              end
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b0;
              pstate <= P_EMPTY;
            end
`ifdef HEX_RX_PREFIX_EN
            else if (cnt == CW'(1) && acc == '0 &&
                     (byte_data == ASCII_LX || byte_data == ASCII_UX)) begin
              cnt <= '0;
            end
`endif
            else if (dec[4] && cnt < CW'(DIGITS)) begin
              acc <= VW'({acc, dec[3:0]});
              cnt <= cnt + CW'(1);
            end else begin
              pstate <= P_DISCARD;
            end
          end
          P_DISCARD: begin
            if (term) begin
              parse_err <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              busy      <= 1'b0;
              pstate    <= P_EMPTY;
            end
          end
          default: pstate <= P_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_cmd_rx.sv
// Directed bench for uart_hex_cmd_rx: a table of text lines with expected pulse counts and values,
// followed by hand-written sequences for glitch, framing error and mid-frame reset.
module tb_uart_hex_cmd_rx;

  localparam int BIT_CLKS = 16;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_pin;
  logic [15:0] hex_val;
  logic        hex_valid;
  logic        parse_err;
  logic        frame_err;
  logic        busy;

  int checks;
  int errors;
  int n_valid;
  int n_perr;
  int n_ferr;

  typedef struct {
    logic [63:0] txt;
    int          len;
    int          exp_valid;
    int          exp_perr;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs [9];

  uart_hex_cmd_rx #(.DIGITS(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_div  (baud_div),
    .rx_pin    (rx_pin),
    .hex_val   (hex_val),
    .hex_valid (hex_valid),
    .parse_err (parse_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters; a pulse wider than one clock counts more than once.
  always @(negedge clk) begin
    if (hex_valid) n_valid++;
    if (parse_err) n_perr++;
    if (frame_err) n_ferr++;
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_pin = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rx_pin = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_text(input logic [63:0] txt, input int len);
    for (int i = 0; i < len; i++)
      send_byte(txt[8*(len-1-i) +: 8], 1'b1);
  endtask

  task automatic apply_stimulus(input int idx);
    int v0, p0, f0;
    v0 = n_valid;
    p0 = n_perr;
    f0 = n_ferr;
    send_text(vecs[idx].txt, vecs[idx].len);
    repeat (20) @(negedge clk);
    check_output($sformatf("vec%0d hex_valid count", idx), n_valid - v0, vecs[idx].exp_valid);
    check_output($sformatf("vec%0d parse_err count", idx), n_perr - p0, vecs[idx].exp_perr);
    check_output($sformatf("vec%0d frame_err count", idx), n_ferr - f0, 0);
    check_output($sformatf("vec%0d hex_val", idx), int'(hex_val), int'(vecs[idx].exp_val));
    check_output($sformatf("vec%0d busy", idx), int'(busy), 0);
  endtask

  initial begin
    int v0, p0, f0;
    checks   = 0;
    errors   = 0;
    n_valid  = 0;
    n_perr   = 0;
    n_ferr   = 0;
    baud_div = 16'd16;
    rx_pin   = 1'b1;
    rst      = 1'b1;

    vecs[0] = '{"ABCD\015\012", 6, 1, 0, 16'hABCD};
    vecs[1] = '{"1f\012",       3, 1, 0, 16'h001F};
    vecs[2] = '{"\015\012",     2, 0, 0, 16'h001F};
    vecs[3] = '{"12345\015",    6, 0, 1, 16'h001F};
    vecs[4] = '{"7\015",        2, 1, 0, 16'h0007};
    vecs[5] = '{"12G4\015",     5, 0, 1, 16'h0007};
    vecs[6] = '{"a\015",        2, 1, 0, 16'h000A};
`ifdef HEX_RX_PREFIX_EN
    vecs[7] = '{"0x00FF\015",   7, 1, 0, 16'h00FF};
    vecs[8] = '{"0x\015",       3, 0, 1, 16'h00FF};
`else
    vecs[7] = '{"0x00FF\015",   7, 0, 1, 16'h000A};
    vecs[8] = '{"0x\015",       3, 0, 1, 16'h000A};
`endif

    repeat (3) @(negedge clk);
    check_output("reset hex_val", int'(hex_val), 0);
    check_output("reset hex_valid", int'(hex_valid), 0);
    check_output("reset parse_err", int'(parse_err), 0);
    check_output("reset frame_err", int'(frame_err), 0);
    check_output("reset busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++)
      apply_stimulus(i);

    // busy rises with the first character and falls on the terminator
    send_byte(8'h35, 1'b1);
    check_output("busy after first char", int'(busy), 1);
    send_byte(8'h0D, 1'b1);
    check_output("busy after CR", int'(busy), 0);
    check_output("hex_val after 5 CR", int'(hex_val), 16'h0005);

    // one-clock glitch on idle line must be rejected as a false start
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    rx_pin = 1'b0;
    @(negedge clk);
    rx_pin = 1'b1;
    repeat (200) @(negedge clk);
    check_output("glitch frame_err", n_ferr - f0, 0);
    check_output("glitch busy", int'(busy), 0);
    check_output("glitch hex_valid", n_valid - v0, 0);

    // stop bit low: frame_err pulse and byte dropped
    f0 = n_ferr;
    send_byte(8'h41, 1'b0);
    repeat (5) @(negedge clk);
    check_output("framing frame_err", n_ferr - f0, 1);
    check_output("framing byte dropped busy", int'(busy), 0);

    // reset in the middle of a frame after a partial line
    send_text("AB", 2);
    check_output("partial line busy", int'(busy), 1);
    rx_pin = 1'b0;
    repeat (5 * BIT_CLKS) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midframe reset hex_val", int'(hex_val), 0);
    check_output("midframe reset busy", int'(busy), 0);
    check_output("midframe reset hex_valid", int'(hex_valid), 0);
    check_output("midframe reset frame_err", int'(frame_err), 0);
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_text("9\015", 2);
    repeat (20) @(negedge clk);
    check_output("post reset hex_val", int'(hex_val), 16'h0009);
    check_output("post reset hex_valid count", n_valid - v0, 1);
    check_output("post reset parse_err count", n_perr - p0, 0);
    check_output("post reset frame_err count", n_ferr - f0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_hex_cmd_rx.md
Name: uart_hex_cmd_rx

Overview:
- Receive-side counterpart to the hex logger; decodes ASCII hex lines typed on a UART terminal into a parallel value.
- Self-contained 8N1 receiver deserialises bytes from rx_pin.
- A line parser accumulates hex digits and emits one value per CR/LF-terminated line.
- Used to poke test codes, addresses and register values into a design from a host terminal.

Parameters:
- DIGITS, 4, maximum hex digits per line; value width is 4*DIGITS.
- SYNC_STAGES, 2, number of flops in the rx_pin metastability synchroniser (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- baud_div  in  16  clocks per bit (F_CLK/BAUD); must be >= 4; latched at each start-bit detect.
- rx_pin  in  1  UART 8N1 serial input; idles high.
- hex_val  out  4*DIGITS  last accepted value; held until the next accepted line.
- hex_valid  out  1  one-cycle pulse when hex_val updates.
- parse_err  out  1  one-cycle pulse on the terminator of a rejected line.
- frame_err  out  1  one-cycle pulse when a stop bit samples low.
- busy  out  1  high while a line holds at least one character and is not yet terminated.

Behaviour:
- Reset values: all outputs 0. Synchroniser flops reset to 1. Both FSMs go to their idle state. Reset mid-frame or mid-line discards all partial data.
- Byte receiver FSM, states R_IDLE, R_START, R_DATA, R_STOP:
  - R_IDLE -> R_START on a synchronised falling edge. Latch baud_div; counter = baud_div>>1.
  - R_START: at counter expiry, if rx is still low, go to R_DATA with counter = baud_div-1. Otherwise it was a glitch; return to R_IDLE.
  - R_DATA: sample 8 bits LSB-first, one per baud_div clocks.
  - R_STOP: sample one bit. If high, pulse byte_valid with byte_data for 1 cycle. If low, pulse frame_err and drop the byte. Either way return to R_IDLE the same cycle.
- Line parser FSM, states P_EMPTY, P_ACCUM, P_DISCARD; it acts only on byte_valid.
  - Digit characters are '0'-'9', 'A'-'F' and 'a'-'f'. Each digit does acc <= {acc[4*DIGITS-5:0], nibble} and cnt <= cnt+1.
  - P_EMPTY:
    - Digit: load it, go to P_ACCUM, busy=1.
    - CR (0x0D) or LF (0x0A): ignored. A CRLF pair therefore yields one value, and blank lines are silent.
    - Any other byte: go to P_DISCARD, busy=1.
  - P_ACCUM:
    - Digit with cnt < DIGITS: accumulate.
    - Digit with cnt == DIGITS (overflow): go to P_DISCARD.
    - CR/LF: next cycle hex_val <= acc (zero-extended, so "1F" gives 0x001F) and hex_valid=1. Clear acc and cnt, busy=0, go to P_EMPTY.
    - Any other byte: go to P_DISCARD.
  - P_DISCARD: ignore all bytes until CR/LF. On the terminator, pulse parse_err, leave hex_val unchanged, clear acc and cnt, busy=0, go to P_EMPTY.
- Latency: hex_valid asserts 1 clk after the byte_valid of the terminator. byte_valid is at the centre of the stop bit.
- The receiver never stalls: bytes arrive at most once per 10*baud_div clocks, and the parser consumes each in 1 cycle, so no FIFO is needed.
- Counters are 16-bit. A baud_div change mid-frame takes effect on the next start bit.

Optional Feature:
- Macro HEX_RX_PREFIX_EN.
- Defined:
  - In P_ACCUM with cnt==1 and acc==0 (a single '0' received), 'x' or 'X' clears cnt and stays in P_ACCUM, so "0x1234" parses to 0x1234.
  - A line consisting only of "0x" followed by CR/LF yields parse_err.
- Not defined: 'x' is an ordinary invalid character and sends the parser to P_DISCARD.

Decomposition:
- Package uart_hex_pkg holds:
  - ASCII constants (CR, LF, '0', 'A', 'a', 'x').
  - Receiver and parser state enums.
  - Function ascii_to_nibble returning {is_digit, nibble}.
- One sub-module: uart_rx_8n1 (synchroniser, byte receiver FSM, byte_valid/byte_data/frame_err outputs). The parser stays in the top level.

Test Plan:
- baud_div=16; send "ABCD\r\n": one hex_valid, hex_val=0xABCD, no parse_err; busy falls on CR.
- Send "1f\n", then "\r\n": hex_val=0x001F with exactly one hex_valid; the blank line gives no pulses.
- Send "12345\r", then "7\r": parse_err once and hex_val stays 0x001F; then hex_val=0x0007.
- Send "12G4\r": parse_err pulse, no hex_valid; a 1-clock low glitch on idle rx_pin gives no byte and no frame_err.
- Send byte 0x41 with stop bit forced low: frame_err pulse, byte dropped. Assert rst mid-frame after "AB": all outputs 0; a following "9\r" gives 0x0009.
- With HEX_RX_PREFIX_EN, "0x00FF\r" gives 0x00FF. Without it, the same input gives parse_err and no hex_valid.
